// File: rtl/edge_sync_detect.sv
// Pin synchroniser and edge detector with a millisecond hold-off after each event.
// Optional EDGE_CNT_EN macro adds a saturating event counter (Edge_cnt) with clear (Cnt_clr).
module edge_sync_detect #(
    parameter logic [13:0] T1MS_CYC   = 14'd12000,
    parameter logic [4:0]  HOLDOFF_MS = 5'd20,
    parameter logic        IDLE_LEVEL = 1'b1
) (
    input  logic       Sys_clk,
    input  logic       Sys_reset,
    input  logic       Pin_in,
`ifdef EDGE_CNT_EN
    input  logic       Cnt_clr,
    output logic [7:0] Edge_cnt,
`endif
    output logic       H2L_sig,
    output logic       L2H_sig,
    output logic       Level_out,
    output logic       Busy
);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t      state, state_nxt;
    logic        sync1, sync2;
    logic [13:0] presc, presc_nxt;
    logic [4:0]  ms_cnt, ms_nxt;
    logic [5:0]  ms_inc;
    logic        level_nxt, h2l_nxt, l2h_nxt;

    // Two-flop synchroniser; only sync2 is trusted downstream.
    always_ff @(posedge Sys_clk or negedge Sys_reset) begin
        if (!Sys_reset) begin
            sync1 <= IDLE_LEVEL;
            sync2 <= IDLE_LEVEL;
        end else begin
            sync1 <= Pin_in;
            sync2 <= sync1;
        end
    end

    assign ms_inc = {1'b0, ms_cnt} + 6'd1;

    always_comb begin
        state_nxt = state;
        presc_nxt = presc;
        ms_nxt    = ms_cnt;
        level_nxt = Level_out;
        h2l_nxt   = 1'b0;
        l2h_nxt   = 1'b0;
        if (state == IDLE) begin
            if (sync2 != Level_out) begin
                h2l_nxt   = Level_out;
                l2h_nxt   = ~Level_out;
                level_nxt = sync2;
                presc_nxt = '0;
                ms_nxt    = '0;
                state_nxt = HOLD;
            end
        end else begin
            // Pin activity is ignored here; the exit compare picks up any settled change.
            if (presc == T1MS_CYC - 14'd1) begin
                presc_nxt = '0;
                if (ms_inc == {1'b0, HOLDOFF_MS}) begin
                    ms_nxt    = '0;
                    state_nxt = IDLE;
                end else begin
                    ms_nxt = ms_inc[4:0];
                end
            end else begin
                presc_nxt = presc + 14'd1;
            end
        end
    end

    always_ff @(posedge Sys_clk or negedge Sys_reset) begin
        if (!Sys_reset) begin
            state     <= IDLE;
            presc     <= '0;
            ms_cnt    <= '0;
            Level_out <= IDLE_LEVEL;
            H2L_sig   <= 1'b0;
            L2H_sig   <= 1'b0;
        end else begin
            state     <= state_nxt;
            presc     <= presc_nxt;
            ms_cnt    <= ms_nxt;
            Level_out <= level_nxt;
            H2L_sig   <= h2l_nxt;
            L2H_sig   <= l2h_nxt;
        end
    end

    assign Busy = (state == HOLD);

`ifdef EDGE_CNT_EN
    // Counts visible pulses; clear has priority over a same-cycle pulse.
    always_ff @(posedge Sys_clk or negedge Sys_reset) begin
        if (!Sys_reset) begin
            Edge_cnt <= 8'd0;
        end else if (Cnt_clr) begin
            Edge_cnt <= 8'd0;
        end else if ((H2L_sig || L2H_sig) && (Edge_cnt != 8'hFF)) begin
            Edge_cnt <= Edge_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_edge_sync_detect.sv
// Self-checking bench for edge_sync_detect (T1MS_CYC=4, HOLDOFF_MS=3 -> 12-cycle hold-off).
module tb_edge_sync_detect;

    localparam int HC = 12;

    logic Sys_clk = 1'b0;
    logic Sys_reset = 1'b0;
    logic Pin_in = 1'b1;
    logic H2L_sig, L2H_sig, Level_out, Busy;
`ifdef EDGE_CNT_EN
    logic       Cnt_clr = 1'b0;
    logic [7:0] Edge_cnt;
`endif

    always #5 Sys_clk = ~Sys_clk;

    edge_sync_detect #(
        .T1MS_CYC  (14'd4),
        .HOLDOFF_MS(5'd3),
        .IDLE_LEVEL(1'b1)
    ) dut (
        .Sys_clk  (Sys_clk),
        .Sys_reset(Sys_reset),
        .Pin_in   (Pin_in),
`ifdef EDGE_CNT_EN
        .Cnt_clr  (Cnt_clr),
        .Edge_cnt (Edge_cnt),
`endif
        .H2L_sig  (H2L_sig),
        .L2H_sig  (L2H_sig),
        .Level_out(Level_out),
        .Busy     (Busy)
    );

    typedef struct {
        logic pin;
        logic h2l;
        logic l2h;
        logic lvl;
        logic busy;
    } vec_t;

    vec_t tbl[18];

    int   total = 0;
    int   bad = 0;
    // Reference model: edge count since reset, sample history, last event edge.
    int   n;
    int   e;
    logic m_lvl, m_h2l, m_l2h, m_busy;
    logic q[$];
    int   h2l_cnt, l2h_cnt, last_h2l_n, last_l2h_n;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (edge %0d)", nm, act, exp, n);
        end
    endtask

    task automatic model_reset();
        n = 0;
        e = -1000;
        q.delete();
        q.push_back(1'b1);
        q.push_back(1'b1);
        m_lvl = 1'b1; m_h2l = 1'b0; m_l2h = 1'b0; m_busy = 1'b0;
        h2l_cnt = 0; l2h_cnt = 0; last_h2l_n = -1; last_l2h_n = -1;
    endtask

    // At edge n the detector sees the pin applied before edge n-2, and may
    // act only once 13 edges have passed since the previous event.
    task automatic model_edge(input logic p);
        logic s;
        n++;
        q.push_back(p);
        s = q[q.size() - 3];
        m_h2l = 1'b0;
        m_l2h = 1'b0;
        if (n >= e + HC + 1 && s != m_lvl) begin
            if (m_lvl) m_h2l = 1'b1;
            else       m_l2h = 1'b1;
            m_lvl = s;
            e = n;
        end
        m_busy = (n >= e) && (n < e + HC);
    endtask

    task automatic tick(input logic p);
        Pin_in = p;
        @(posedge Sys_clk);
        model_edge(p);
        #1;
        chk("h2l", int'(H2L_sig), int'(m_h2l));
        chk("l2h", int'(L2H_sig), int'(m_l2h));
        chk("level", int'(Level_out), int'(m_lvl));
        chk("busy", int'(Busy), int'(m_busy));
        if (H2L_sig) begin h2l_cnt++; last_h2l_n = n; end
        if (L2H_sig) begin l2h_cnt++; last_l2h_n = n; end
    endtask

    task automatic do_reset(input logic p);
        @(negedge Sys_clk);
        Pin_in = p;
        Sys_reset = 1'b0;
        #1;
        model_reset();
        chk("rst_busy", int'(Busy), 0);
        chk("rst_level", int'(Level_out), 1);
        chk("rst_pulses", int'(H2L_sig) + int'(L2H_sig), 0);
        @(negedge Sys_clk);
        @(negedge Sys_clk);
        Sys_reset = 1'b1;
    endtask

    initial begin
        int k;
        logic v;
        model_reset();

        for (int i = 0; i < 18; i++) begin
            tbl[i].pin  = (i >= 15);
            tbl[i].h2l  = (i == 2);
            tbl[i].l2h  = (i == 17);
            tbl[i].lvl  = (i < 2) || (i == 17);
            tbl[i].busy = (i >= 2 && i <= 13) || (i == 17);
        end

        // Idle with the pin at its rest level: nothing happens.
        do_reset(1'b1);
        for (int i = 0; i < 50; i++) tick(1'b1);
        chk("idle_no_pulse", h2l_cnt + l2h_cnt, 0);

        // Fall/rise latency and hold-off length from the table.
        do_reset(1'b1);
        for (int i = 0; i < 18; i++) begin
            Pin_in = tbl[i].pin;
            @(posedge Sys_clk);
            model_edge(tbl[i].pin);
            #1;
            chk("tbl_h2l", int'(H2L_sig), int'(tbl[i].h2l));
            chk("tbl_l2h", int'(L2H_sig), int'(tbl[i].l2h));
            chk("tbl_level", int'(Level_out), int'(tbl[i].lvl));
            chk("tbl_busy", int'(Busy), int'(tbl[i].busy));
        end

        // Bounce during hold-off, settling at the new level.
        do_reset(1'b1);
        tick(1'b0); tick(1'b0);
        for (int i = 0; i < 10; i++) tick(((i / 2) % 2) == 0);
        for (int i = 0; i < 30; i++) tick(1'b0);
        chk("bounce_h2l_cnt", h2l_cnt, 1);
        chk("bounce_l2h_cnt", l2h_cnt, 0);
        chk("bounce_level", int'(Level_out), 0);

        // Rise inside hold-off is reported right at hold-off exit.
        do_reset(1'b1);
        for (int i = 0; i < 6; i++) tick(1'b0);
        for (int i = 0; i < 20; i++) tick(1'b1);
        chk("late_rise_gap", last_l2h_n - last_h2l_n, 13);
        chk("late_rise_h2l_at", last_h2l_n, 3);
        chk("late_rise_level", int'(Level_out), 1);

        // Reset in the middle of hold-off with the pin held low.
        do_reset(1'b1);
        for (int i = 0; i < 8; i++) tick(1'b0);
        chk("pre_abort_busy", int'(Busy), 1);
        do_reset(1'b0);
        k = 0;
        while (h2l_cnt == 0 && k < 10) begin
            tick(1'b0);
            k++;
        end
        chk("abort_h2l_edge", k, 3);

        // Random pin runs against the model.
        do_reset(1'b1);
        for (int b = 0; b < 120; b++) begin
            v = 1'($urandom_range(0, 1));
            k = $urandom_range(1, 20);
            for (int i = 0; i < k; i++) tick(v);
        end
        chk("rand_alternation", (h2l_cnt - l2h_cnt) inside {0, 1}, 1);

`ifdef EDGE_CNT_EN
        do_reset(1'b1);
        chk("cnt_reset", int'(Edge_cnt), 0);
        v = 1'b1;
        for (int t = 0; t < 300; t++) begin
            v = ~v;
            for (int i = 0; i < 16; i++) tick(v);
        end
        chk("cnt_pulses", h2l_cnt + l2h_cnt, 300);
        chk("cnt_sat", int'(Edge_cnt), 255);
        v = ~v;
        k = 0;
        while (!(H2L_sig || L2H_sig) && k < 10) begin
            tick(v);
            k++;
        end
        chk("cnt_pulse_seen", int'(H2L_sig || L2H_sig), 1);
        Cnt_clr = 1'b1;
        tick(v);
        Cnt_clr = 1'b0;
        chk("cnt_clr_wins", int'(Edge_cnt), 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/edge_sync_detect.md
Name: edge_sync_detect

Overview:
- Input-side companion of the debounce delay block: samples a raw, bouncing key/pin level on Sys_clk.
- Produces one-cycle H2L_sig / L2H_sig event pulses that drive the debounce delay block's pulse inputs.
- Synchronises the asynchronous pin, tracks the last reported level, and enforces a millisecond hold-off after every event so contact bounce cannot generate event bursts.

Parameters:
T1MS_CYC, 14'd12000, Sys_clk cycles per 1 ms tick (12 MHz clock); legal 1..16383
HOLDOFF_MS, 5'd20, hold-off length in ms after each emitted event; legal 1..31
IDLE_LEVEL, 1'b1, pin level assumed at reset (pulled-up key = 1)

Ports:
Sys_clk  input  1  system clock, 12 MHz
Sys_reset  input  1  asynchronous active-low reset
Pin_in  input  1  raw asynchronous pin level
H2L_sig  output  1  one-cycle pulse: reported level changed 1->0
L2H_sig  output  1  one-cycle pulse: reported level changed 0->1
Level_out  output  1  last reported (accepted) level
Busy  output  1  high while in hold-off

Behaviour:
- Reset (Sys_reset=0, async):
  - sync1, sync2 and Level_out = IDLE_LEVEL.
  - H2L_sig, L2H_sig and Busy = 0.
  - Prescaler and ms counter = 0; state = IDLE.
- Synchroniser: two flops, sync1 <= Pin_in, sync2 <= sync1. Only sync2 is used downstream.
- State IDLE (Busy=0):
  - If sync2 != Level_out at a clock edge, register the event:
    - H2L_sig=1 if Level_out was 1, else L2H_sig=1.
    - Level_out <= sync2.
    - Clear the counters; state <= HOLD.
  - Otherwise stay in IDLE with pulses 0.
- State HOLD (Busy=1):
  - Prescaler counts 0..T1MS_CYC-1 and wraps to 0. On the wrap, ms counter +1.
  - When ms counter reaches HOLDOFF_MS at a wrap: clear both counters, state <= IDLE.
  - HOLD lasts exactly HOLDOFF_MS*T1MS_CYC cycles.
  - Pin activity during HOLD is ignored and not queued.
- Hold-off exit: the first IDLE cycle compares sync2 with Level_out. A level that differs at that point produces its event immediately, so no settled level is ever lost.
- Pulses: exactly one cycle wide; H2L_sig and L2H_sig are never high together; they alternate strictly.
- Latency: for a Pin_in change meeting setup before edge k, the pulse is high in the cycle following edge k+2 (provided the block is in IDLE).
- Minimum spacing between two pulses: HOLDOFF_MS*T1MS_CYC+1 cycles.
- Reset mid-HOLD: aborts immediately with no pulse. After release, if the pin is at IDLE_LEVEL, no event is produced.
- Widths: prescaler 14 bits, ms counter 5 bits; no overflow is possible within the legal parameter ranges.

Optional Feature:
- Macro: EDGE_CNT_EN.
- Defined:
  - Adds input Cnt_clr (1 bit, synchronous clear) and output Edge_cnt (8 bits, reset 0).
  - Edge_cnt increments on every emitted pulse and saturates at 255.
  - Cnt_clr=1 forces 0 and wins over a same-cycle increment.
- Undefined: neither port exists and no counter logic is built.

Test Plan:
All scenarios use T1MS_CYC=4, HOLDOFF_MS=3 (hold-off = 12 cycles).
- Reset release with Pin_in=1 held for 50 cycles -> no pulses, Level_out=1, Busy=0 throughout.
- Pin_in 1->0 before edge k -> H2L_sig high only in the cycle after edge k+2; Level_out=0; Busy high exactly 12 cycles; no L2H_sig.
- After the fall, Pin_in toggles every 2 cycles for 10 cycles, then settles at 0 -> exactly one H2L_sig pulse, zero L2H_sig.
- Fall produces H2L at cycle t; Pin_in rises at HOLD cycle 5 and stays 1 -> L2H_sig pulse at cycle t+13; Level_out=1.
- Sys_reset asserted at HOLD cycle 6 with Pin_in=0 -> Busy=0, Level_out=1 immediately; after release, H2L_sig pulses after the 3rd clock edge.
- With EDGE_CNT_EN defined: 300 well-spaced pin transitions -> Edge_cnt=255; Cnt_clr in the same cycle as a pulse -> Edge_cnt=0 next cycle.
